// File: rtl/voice_mixer_pwm.sv
// voice_mixer_pwm
// Final audio stage of the synth APU. Four square-wave voices are generated
// from half-period inputs, summed into an 8-bit mix, and rendered as a
// 256-cycle-frame PWM stream for an external RC filter.
//
// Ports:
//   clk           system clock
//   reset         synchronous reset, active low; clears every register
//   enable        1 = RUN, 0 = IDLE (silent; only sample is retained)
//   period0..3    half-period of each voice in clk cycles, 0 = voice off
//   sample        mix value latched at the last frame boundary
//   sample_valid  one-cycle strobe when sample updates
//   pwm_out       registered PWM output, high for sample/256 of a frame
module voice_mixer_pwm #(
    parameter int PERIOD_W = 20,
    parameter int AMP      = 63
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period0,
    input  logic [PERIOD_W-1:0] period1,
    input  logic [PERIOD_W-1:0] period2,
    input  logic [PERIOD_W-1:0] period3,
    output logic [7:0]          sample,
    output logic                sample_valid,
    output logic                pwm_out
);

    // Output level of one voice; 4*AMP must fit in 8 bits so the sum never wraps.
    function automatic logic [7:0] voice_level(input logic ph);
        return ph ? 8'(AMP) : 8'd0;
    endfunction

    logic [PERIOD_W-1:0] w_period [4];
    logic [PERIOD_W-1:0] r_cnt_p0 [4];
    logic [3:0]          r_phase_p0;
    logic [7:0]          w_mix;
    logic [7:0]          r_mix_p1;
    logic [7:0]          r_pwm_cnt;
    logic [7:0]          r_duty_p2;
    logic [7:0]          r_sample_p2;
    logic                r_valid_p2;
    logic                r_pwm_out_p3;
    logic                w_frame_end;

    assign w_period[0] = period0;
    assign w_period[1] = period1;
    assign w_period[2] = period2;
    assign w_period[3] = period3;

    // Stage p0: oscillators. The >= compare makes a shrinking period wrap
    // on the next cycle instead of letting the counter run to overflow.
    always_ff @(posedge clk) begin
        if (!reset || !enable) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt_p0[i] <= '0;
            end
            r_phase_p0 <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_period[i] == '0) begin
                    r_cnt_p0[i]   <= '0;
                    r_phase_p0[i] <= 1'b0;
                end else if (r_cnt_p0[i] >= w_period[i] - PERIOD_W'(1)) begin
                    r_cnt_p0[i]   <= '0;
                    r_phase_p0[i] <= ~r_phase_p0[i];
                end else begin
                    r_cnt_p0[i]   <= r_cnt_p0[i] + PERIOD_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_mix = voice_level(r_phase_p0[0]) + voice_level(r_phase_p0[1])
              + voice_level(r_phase_p0[2]) + voice_level(r_phase_p0[3]);
    end

    assign w_frame_end = (r_pwm_cnt == 8'hFF);

    // Stage p1: registered mix; stage p2: frame latch of the registered mix
    // (a toggle landing on the frame-end cycle shows up one frame later);
    // stage p3: PWM comparator.
    always_ff @(posedge clk) begin
        if (!reset || !enable) begin
            r_mix_p1     <= 8'd0;
            r_pwm_cnt    <= 8'd0;
            r_duty_p2    <= 8'd0;
            r_valid_p2   <= 1'b0;
            r_pwm_out_p3 <= 1'b0;
        end else begin
            r_mix_p1     <= w_mix;
            r_pwm_cnt    <= r_pwm_cnt + 8'd1;
            r_valid_p2   <= w_frame_end;
            r_pwm_out_p3 <= (r_pwm_cnt < r_duty_p2);
            if (w_frame_end) begin
                r_duty_p2 <= r_mix_p1;
            end
        end
    end

    // sample survives IDLE; only reset clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sample_p2 <= 8'd0;
        end else if (enable && w_frame_end) begin
            r_sample_p2 <= r_mix_p1;
        end
    end

    assign sample       = r_sample_p2;
    assign sample_valid = r_valid_p2;
    assign pwm_out      = r_pwm_out_p3;

endmodule

// File: tb/tb_voice_mixer_pwm.sv
module tb_voice_mixer_pwm;

    localparam int PW  = 20;
    localparam int AMP = 63;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [PW-1:0] p [4];
    logic [7:0]    sample;
    logic          sv;
    logic          pwm;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: timestamp-based voices and frame arithmetic.
    int m_n;           // enabled edges since last reset/idle
    int m_ts [4];      // edge index where each voice's half-period started
    int m_ph [4];
    int m_mix, m_duty, m_sample, m_sv, m_pwm;

    voice_mixer_pwm #(.PERIOD_W(PW), .AMP(AMP)) dut (
        .clk(clk), .reset(rst_n), .enable(en),
        .period0(p[0]), .period1(p[1]), .period2(p[2]), .period3(p[3]),
        .sample(sample), .sample_valid(sv), .pwm_out(pwm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear(input bit keep_sample);
        m_n = 0;
        for (int v = 0; v < 4; v++) begin
            m_ts[v] = 0;
            m_ph[v] = 0;
        end
        m_mix = 0; m_duty = 0; m_sv = 0; m_pwm = 0;
        if (!keep_sample) m_sample = 0;
    endtask

    task automatic model_edge();
        int k, pc, per;
        if (!rst_n) begin
            model_clear(1'b0);
        end else if (!en) begin
            model_clear(1'b1);
        end else begin
            k  = m_n + 1;
            pc = m_n % 256;
            m_pwm = (pc < m_duty) ? 1 : 0;
            if (pc == 255) begin
                m_duty   = m_mix;
                m_sample = m_mix;
                m_sv     = 1;
            end else begin
                m_sv = 0;
            end
            m_mix = AMP * (m_ph[0] + m_ph[1] + m_ph[2] + m_ph[3]);
            for (int v = 0; v < 4; v++) begin
                per = int'(p[v]);
                if (per == 0) begin
                    m_ph[v] = 0;
                    m_ts[v] = k;
                end else if (k - m_ts[v] >= per) begin
                    m_ph[v] = 1 - m_ph[v];
                    m_ts[v] = k;
                end
            end
            m_n = k;
        end
    endtask

    // One clock: model follows the inputs held across the edge, outputs
    // are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        chk("sample", int'(sample), m_sample);
        chk("valid", int'(sv), m_sv);
        chk("pwm", int'(pwm), m_pwm);
    endtask

    task automatic set_p(input int a, input int b, input int c, input int d);
        p[0] = PW'(a); p[1] = PW'(b); p[2] = PW'(c); p[3] = PW'(d);
    endtask

    initial begin
        int hi, cnt, s, gap;
        bit seen;
        model_clear(1'b0);
        rst_n = 1'b0; en = 1'b1; set_p(0, 0, 0, 0);

        // Reset with enable high, then silence for four frames.
        step(); step();
        chk("rst_pwm", int'(pwm), 0);
        chk("rst_sample", int'(sample), 0);
        chk("rst_valid", int'(sv), 0);
        rst_n = 1'b1;
        hi = 0;
        repeat (1024) begin step(); hi += int'(pwm); end
        chk("silent_pwm_high", hi, 0);
        chk("silent_sample", int'(sample), 0);

        // Single voice.
        set_p(4, 0, 0, 0);
        cnt = 0;
        repeat (512) begin
            step();
            if (sv) begin
                cnt++;
                chk("single_value", (sample == 8'd0 || sample == 8'd63) ? 1 : 0, 1);
            end
        end
        chk("single_pulses", cnt, 2);

        // Full chord from a fresh RUN entry: all four high by the 2nd frame.
        en = 1'b0; step(); en = 1'b1;
        set_p(300, 301, 302, 303);
        repeat (512) step();
        chk("chord_valid", int'(sv), 1);
        chk("chord_sample", int'(sample), 252);
        s = int'(sample);
        for (int f = 0; f < 4; f++) begin
            if (f == 1) set_p(300, 400, 500, 600);
            hi = 0;
            repeat (256) begin step(); hi += int'(pwm); end
            chk("frame_duty", hi, s);
            chk("frame_valid", int'(sv), 1);
            chk("frame_multiple", int'(sample) % 63, 0);
            s = int'(sample);
        end

        // Period shrink below the running count.
        set_p(0, 1000, 0, 0);
        repeat (700) step();
        p[1] = PW'(10);
        repeat (300) step();

        // Enable drop at pwm_cnt = 100 with a non-zero sample held.
        en = 1'b0; step(); en = 1'b1;
        set_p(300, 301, 302, 303);
        repeat (612) step();
        s = int'(sample);
        chk("pre_drop_sample", s, 252);
        en = 1'b0; step();
        chk("drop_pwm", int'(pwm), 0);
        chk("drop_sample", int'(sample), s);
        chk("drop_valid", int'(sv), 0);
        en = 1'b1;
        gap = 0; seen = 1'b0;
        while (!seen && gap < 300) begin
            step(); gap++;
            if (sv) seen = 1'b1;
        end
        chk("reenable_gap", gap, 256);

        // Mid-run reset.
        set_p(0, 0, 3, 0);
        repeat (300) step();
        rst_n = 1'b0; step();
        chk("midrst_sample", int'(sample), 0);
        chk("midrst_pwm", int'(pwm), 0);
        chk("midrst_valid", int'(sv), 0);
        rst_n = 1'b1;
        repeat (600) step();

        // Randomized run: period changes, occasional idle and reset.
        for (int c = 0; c < 40 * 256; c++) begin
            if ($urandom_range(47, 0) == 0) begin
                int v, sel;
                v = int'($urandom_range(3, 0));
                sel = int'($urandom_range(3, 0));
                if (sel == 0)      p[v] = '0;
                else if (sel == 1) p[v] = PW'($urandom_range(8, 1));
                else               p[v] = PW'($urandom_range(700, 1));
            end
            en    = ($urandom_range(1499, 0) != 0);
            rst_n = ($urandom_range(2999, 0) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
